// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and parity selectors for the configurable UART receiver
package uart_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_rx_state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: one-cycle tick every DIV+1 clocks, phase realigned by restart
module baud_tick_gen #(
  parameter int DIV = 0,
  parameter int W   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV);
  always_ff @(posedge clk)
    if (reset || restart) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with configurable width, parity and stop bits
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int SYS_CLK   = 14000000,
  parameter int RATE      = 9600,
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 din,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int DIV = SYS_CLK / (RATE * OVS) - 1;
  localparam int DW  = DIV > 0 ? $clog2(DIV + 1) : 1;
  localparam int SW  = $clog2(OVS);
  localparam logic [SW-1:0] S_LO  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(OVS / 2);
  localparam logic [SW-1:0] S_HI  = SW'(OVS / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVS - 1);
  localparam logic [3:0] I_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] I_STOP = 4'(STOP_BITS - 1);
  if (DIV < 0 || OVS % 2 != 0 || OVS < 8 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_cfg
    $error("uart_rx_cfg: unsupported parameter set");
  end
  logic sync1, rx_s, rx_d;
  uart_rx_state_t state;
  logic [SW-1:0] s;
  logic [3:0] idx;
  logic [1:0] smp;
  logic bitv, perr_c, ferr_c;
  logic [DATA_BITS-1:0] shreg;
  logic tick, start, maj, at_hi, last, latch;
  assign start = state == ST_IDLE && rx_d && !rx_s;
  assign maj   = (smp[1] & smp[0]) | (smp[1] & rx_s) | (smp[0] & rx_s);
  assign at_hi = tick && s == S_HI;
  assign last  = s == S_END;
  assign latch = at_hi && state == ST_STOP && idx == I_STOP;
  assign busy  = state != ST_IDLE;
  baud_tick_gen #(.DIV(DIV), .W(DW)) u_tick (
    .clk(clk), .reset(reset), .restart(start), .tick(tick)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
      state <= ST_IDLE;
      s <= '0;
      idx <= '0;
      smp <= '0;
      bitv <= 1'b0;
      perr_c <= 1'b0;
      ferr_c <= 1'b0;
      shreg <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sync1 <= din;
      rx_s <= sync1;
      rx_d <= rx_s;
      if (dout_ready) dout_valid <= 1'b0;
      // a new word always wins over the handshake that would clear valid
      if (latch) begin
        dout <= shreg;
        parity_err <= perr_c;
        frame_err <= ferr_c | ~maj;
        dout_valid <= 1'b1;
        overrun <= overrun | (dout_valid & ~dout_ready);
      end
      if (state == ST_IDLE) begin
        s <= '0;
        if (start) begin
          state <= ST_START;
          idx <= '0;
          perr_c <= 1'b0;
          ferr_c <= 1'b0;
        end
      end else if (tick) begin
        s <= last ? '0 : s + 1'b1;
        if (s == S_LO || s == S_MID) smp <= {smp[0], rx_s};
        if (s == S_HI) bitv <= maj;
        case (state)
          ST_START: if (last) state <= bitv ? ST_IDLE : ST_DATA;
          ST_DATA: begin
            if (s == S_HI) shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (last) begin
              idx <= idx == I_DATA ? '0 : idx + 1'b1;
              if (idx == I_DATA) state <= PARITY != PAR_NONE ? ST_PARITY : ST_STOP;
            end
          end
          ST_PARITY: begin
            if (s == S_HI) perr_c <= PARITY == PAR_ODD ? ~(^shreg ^ maj) : (^shreg ^ maj);
            if (last) state <= ST_STOP;
          end
          ST_STOP: begin
            if (s == S_HI) begin
              ferr_c <= ferr_c | ~maj;
              if (idx == I_STOP) state <= ST_IDLE;
            end
            if (last) idx <= idx + 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: randomized scoreboard bench for 8N1 and 7E1 receiver instances
module tb_uart_rx_cfg;
  logic clk = 1'b0, reset = 1'b1;
  logic din8 = 1'b1, din7 = 1'b1, rdy8 = 1'b1, rdy7 = 1'b1;
  logic [7:0] d8;
  logic [6:0] d7;
  logic v8, pe8, fe8, ov8, bz8, v7, pe7, fe7, ov7, bz7;
  int vectors = 0, miscompares = 0;
  logic [9:0] q8[$], q7[$];
  always #5 clk = ~clk;
  uart_rx_cfg #(.SYS_CLK(1600000), .RATE(100000), .OVS(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u8 (
    .clk(clk), .reset(reset), .din(din8), .dout(d8), .dout_valid(v8), .dout_ready(rdy8),
    .parity_err(pe8), .frame_err(fe8), .overrun(ov8), .busy(bz8));
  uart_rx_cfg #(.SYS_CLK(1600000), .RATE(100000), .OVS(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u7 (
    .clk(clk), .reset(reset), .din(din7), .dout(d7), .dout_valid(v7), .dout_ready(rdy7),
    .parity_err(pe7), .frame_err(fe7), .overrun(ov7), .busy(bz7));
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drive(input int w, input logic v);
    if (w == 0) din8 = v; else din7 = v;
  endtask
  task automatic frame(input int w, input logic [15:0] bits, input int n, input int gpos);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        drive(w, (i * 16 + c == gpos) ? ~bits[i] : bits[i]);
      end
    @(negedge clk);
    drive(w, 1'b1);
  endtask
  task automatic send8(input logic [7:0] d, input logic stop, input int gpos, input bit push);
    if (push) q8.push_back({1'b0, ~stop, d});
    frame(0, {6'b0, stop, d, 1'b0}, 10, gpos);
  endtask
  task automatic send7(input logic [6:0] d, input bit flip, input logic stop);
    logic p;
    int ones;
    ones = $countones(d);
    p = logic'(ones % 2) ^ logic'(flip);
    q7.push_back({logic'((ones + int'(p)) % 2 != 0), ~stop, 1'b0, d});
    frame(1, {6'b0, stop, p, d, 1'b0}, 10, -1);
  endtask
  always @(negedge clk) begin
    #4;
    if (!reset && v8 && rdy8) begin
      vectors++;
      if (q8.size() == 0) begin
        miscompares++;
        $display("FAIL u8_unexpected got %0h expected none", {pe8, fe8, d8});
      end else begin
        logic [9:0] e;
        e = q8.pop_front();
        if ({pe8, fe8, d8} !== e) begin
          miscompares++;
          $display("FAIL u8_word got %0h expected %0h", {pe8, fe8, d8}, e);
        end
      end
    end
    if (!reset && v7 && rdy7) begin
      vectors++;
      if (q7.size() == 0) begin
        miscompares++;
        $display("FAIL u7_unexpected got %0h expected none", {pe7, fe7, 1'b0, d7});
      end else begin
        logic [9:0] e;
        e = q7.pop_front();
        if ({pe7, fe7, 1'b0, d7} !== e) begin
          miscompares++;
          $display("FAIL u7_word got %0h expected %0h", {pe7, fe7, 1'b0, d7}, e);
        end
      end
    end
  end
  initial begin
    int t;
    idle(3);
    check("rst_out8", {d8, v8, pe8, fe8, ov8, bz8}, 0);
    check("rst_out7", {d7, v7, pe7, fe7, ov7, bz7}, 0);
    reset = 1'b0;
    idle(5);
    send8(8'hA5, 1'b1, -1, 1);
    idle(20);
    send7(7'h41, 1'b0, 1'b1);
    idle(20);
    send7(7'h41, 1'b1, 1'b1);
    idle(20);
    din8 = 1'b0;
    idle(5);
    din8 = 1'b1;
    t = 0;
    while (!bz8 && t < 10) begin idle(1); t++; end
    check("glitch_busy_rise", bz8, 1);
    t = 0;
    while (bz8 && t < 30) begin idle(1); t++; end
    check("glitch_busy_fall", bz8, 0);
    idle(20);
    send8(8'h3C, 1'b0, -1, 1);
    idle(40);
    q8.push_back({2'b01, 8'h00});
    din8 = 1'b0;
    idle(480);
    din8 = 1'b1;
    idle(40);
    check("break_busy", bz8, 0);
    rdy8 = 1'b0;
    send8(8'h11, 1'b1, -1, 0);
    send8(8'h22, 1'b1, -1, 1);
    idle(20);
    check("ovr_set", ov8, 1);
    check("ovr_word", d8, 8'h22);
    rdy8 = 1'b1;
    idle(5);
    reset = 1'b1;
    idle(2);
    check("ovr_reset", ov8, 0);
    reset = 1'b0;
    idle(3);
    send8(8'h11, 1'b1, -1, 1);
    send8(8'h22, 1'b1, -1, 1);
    idle(20);
    check("no_ovr", ov8, 0);
    for (int k = 7; k <= 9; k++) begin
      send8(8'hFF, 1'b1, 4 * 16 + k, 1);
      idle(10);
    end
    din8 = 1'b0;
    idle(16);
    idle(32);
    check("mid_busy", bz8, 1);
    reset = 1'b1;
    idle(2);
    check("rst_mid8", {d8, v8, pe8, fe8, ov8, bz8}, 0);
    din8 = 1'b1;
    reset = 1'b0;
    idle(200);
    for (int n = 0; n < 24; n++) begin
      send8(8'($urandom), 1'b1, -1, 1);
      idle($urandom_range(0, 20));
    end
    for (int n = 0; n < 24; n++) begin
      send7(7'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      idle(32);
    end
    t = 0;
    while ((q8.size() != 0 || q7.size() != 0) && t < 2000) begin idle(1); t++; end
    while (q8.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL u8_missing got none expected %0h", q8.pop_front());
    end
    while (q7.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL u7_missing got none expected %0h", q7.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
